// File: rtl/regfile_dump_reader.sv
// Streams a contiguous, wrapping index range of a register file out through a
// single combinational read port and a 2-entry registered valid/ready buffer.
module regfile_dump_reader #(
  parameter int width = 32,
  parameter int n     = 5,
  parameter int size  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [n-1:0]     base,
  input  logic [n:0]       count,
  output logic             busy,
  output logic             done,
  output logic [n-1:0]     readReq,
  input  logic [width-1:0] readResp,
  output logic             outValid,
  input  logic             outReady,
  output logic [width-1:0] outData,
  output logic [n-1:0]     outIndex
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [n-1:0] LAST_IDX = n'(size - 1);

  state_t           state_q, state_d;
  logic [n-1:0]     cur_q, cur_d;
  logic [n:0]       rem_q, rem_d;
  logic             done_q, done_d;

  logic [width-1:0] fifo_data_q [2];
  logic [n-1:0]     fifo_idx_q  [2];
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       occ_q, occ_d;
  logic             push, pop;

  assign outValid = (occ_q != 2'd0);
  assign pop      = outValid && outReady;
  assign outData  = fifo_data_q[rd_ptr_q];
  assign outIndex = fifo_idx_q[rd_ptr_q];
  assign readReq  = cur_q;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    push    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (count == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = RUN;
            cur_d   = base;
            rem_d   = count;
          end
        end
      end
      RUN: begin
        // A full buffer still accepts a word when its head leaves this cycle.
        push = (occ_q != 2'd2) || pop;
        if (push) begin
          cur_d = (cur_q == LAST_IDX) ? '0 : cur_q + 1'b1;
          rem_d = rem_q - 1'b1;
          if (rem_q == (n+1)'(1)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (occ_q == 2'd0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    occ_d = occ_q;
    if (push && !pop) begin
      occ_d = occ_q + 2'd1;
    end else if (pop && !push) begin
      occ_d = occ_q - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cur_q   <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        fifo_data_q[i] <= '0;
        fifo_idx_q[i]  <= '0;
      end
    end else begin
      if (push) begin
        fifo_data_q[wr_ptr_q] <= readResp;
        fifo_idx_q[wr_ptr_q]  <= cur_q;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      occ_q <= occ_d;
    end
  end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Bench for regfile_dump_reader: a queue model of the expected beat stream plus
// directed latency, wrap, stall, ignored-start and async-reset scenarios.
`timescale 1ns/1ps
module tb_regfile_dump_reader;
  localparam int W = 32;
  localparam int N = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Instance A: 32 entries
  logic         a_start = 1'b0;
  logic [N-1:0] a_base  = '0;
  logic [N:0]   a_count = '0;
  logic         a_ready = 1'b1;
  logic         a_busy, a_done, a_valid;
  logic [N-1:0] a_req, a_idx;
  logic [W-1:0] a_resp, a_data;
  logic [W-1:0] arr_a [32];
  assign a_resp = arr_a[a_req];

  regfile_dump_reader #(.width(W), .n(N), .size(32)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .base(a_base), .count(a_count),
    .busy(a_busy), .done(a_done), .readReq(a_req), .readResp(a_resp),
    .outValid(a_valid), .outReady(a_ready), .outData(a_data), .outIndex(a_idx)
  );

  // Instance B: 20 entries (non-power-of-two wrap)
  logic         b_start = 1'b0;
  logic [N-1:0] b_base  = '0;
  logic [N:0]   b_count = '0;
  logic         b_ready = 1'b1;
  logic         b_busy, b_done, b_valid;
  logic [N-1:0] b_req, b_idx;
  logic [W-1:0] b_resp, b_data;
  logic [W-1:0] arr_b [20];
  assign b_resp = (b_req < 5'd20) ? arr_b[b_req] : 32'hDEAD_BEEF;

  regfile_dump_reader #(.width(W), .n(N), .size(20)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .base(b_base), .count(b_count),
    .busy(b_busy), .done(b_done), .readReq(b_req), .readResp(b_resp),
    .outValid(b_valid), .outReady(b_ready), .outData(b_data), .outIndex(b_idx)
  );

  // Model: the ordered list of (index, word) beats a sweep must produce.
  int exp_idx[$];
  int exp_dat[$];
  int a_pops  = 0;
  int a_dones = 0;

  task automatic expect_sweep(input int b, input int c);
    for (int i = 0; i < c; i++) begin
      int idx;
      idx = (b + i) % 32;
      exp_idx.push_back(idx);
      exp_dat.push_back(int'(arr_a[idx]));
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (a_done) begin
        a_dones++;
        check("done_before_drained", exp_idx.size() + int'(a_valid), 0);
      end
      if (a_valid) begin
        if (exp_idx.size() == 0) begin
          check("unexpected_beat", a_valid, 0);
        end else begin
          check("beat_index", a_idx, exp_idx[0]);
          check("beat_data", a_data, exp_dat[0]);
          if (a_ready) begin
            void'(exp_idx.pop_front());
            void'(exp_dat.pop_front());
            a_pops++;
          end
        end
      end
    end
  end

  int b_got_idx[$];
  int b_got_dat[$];
  always @(negedge clk) begin
    if (rst_n) begin
      check("b_readreq_range", int'(b_req < 5'd20), 1);
      if (b_valid && b_ready) begin
        b_got_idx.push_back(int'(b_idx));
        b_got_dat.push_back(int'(b_data));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_a(input int b, input int c);
    a_base  = N'(b);
    a_count = (N+1)'(c);
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
  endtask

  task automatic wait_done_a(output int cyc);
    cyc = 0;
    while (!a_done && cyc < 200) begin
      tick();
      cyc++;
    end
    if (!a_done) check("done_timeout", a_done, 1);
  endtask

  logic rdy_pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  int   b_exp_tab [4] = '{18, 19, 0, 1};

  initial begin
    int cyc, p0, d0, occ;
    for (int i = 0; i < 32; i++) arr_a[i] = 32'h100 + W'(i);
    for (int i = 0; i < 20; i++) arr_b[i] = 32'h200 + W'(i);

    #2;
    check("reset_busy", a_busy, 0);
    check("reset_valid", a_valid, 0);
    check("reset_done", a_done, 0);
    check("reset_readreq", a_req, 0);
    #10 rst_n = 1'b1;
    tick();

    // Full sweep, ready held high
    p0 = a_pops; d0 = a_dones;
    expect_sweep(0, 32);
    start_a(0, 32);
    check("t1_valid_k1", a_valid, 0);
    check("t1_readreq_k1", a_req, 0);
    check("t1_busy_k1", a_busy, 1);
    tick();
    check("t1_valid_k2", a_valid, 1);
    check("t1_index_k2", a_idx, 0);
    check("t1_data_k2", a_data, 32'h100);
    wait_done_a(cyc);
    check("t1_done_latency", cyc, 33);
    check("t1_busy_at_done", a_busy, 0);
    tick();
    check("t1_done_width", a_done, 0);
    check("t1_beats", a_pops - p0, 32);
    check("t1_done_count", a_dones - d0, 1);

    // Zero-length sweep
    start_a(5, 0);
    check("t2_done", a_done, 1);
    check("t2_busy", a_busy, 0);
    check("t2_valid", a_valid, 0);
    tick();
    check("t2_done_off", a_done, 0);
    check("t2_busy_off", a_busy, 0);

    // Stalling consumer
    p0 = a_pops; d0 = a_dones;
    expect_sweep(3, 5);
    start_a(3, 5);
    cyc = 0;
    while (!a_done && cyc < 200) begin
      a_ready = rdy_pat[cyc % 6];
      tick();
      cyc++;
      if (a_valid && a_busy) begin
        occ = (int'(a_req) - int'(a_idx) + 32) % 32;
        check("t3_occupancy", int'(occ >= 1 && occ <= 2), 1);
      end
    end
    if (!a_done) check("t3_done_timeout", a_done, 1);
    a_ready = 1'b1;
    tick();
    check("t3_beats", a_pops - p0, 5);
    check("t3_done_count", a_dones - d0, 1);

    // start while busy is ignored
    p0 = a_pops; d0 = a_dones;
    expect_sweep(2, 6);
    start_a(2, 6);
    tick();
    a_base = 5'd10; a_count = 6'd3; a_start = 1'b1;
    tick();
    a_start = 1'b0;
    wait_done_a(cyc);
    repeat (4) tick();
    check("t4_beats", a_pops - p0, 6);
    check("t4_done_count", a_dones - d0, 1);
    check("t4_idle", a_busy, 0);

    // Async reset with two words buffered
    a_ready = 1'b0;
    expect_sweep(4, 10);
    start_a(4, 10);
    tick(); tick();
    check("t5_valid_pre", a_valid, 1);
    check("t5_busy_pre", a_busy, 1);
    check("t5_readreq_pre", a_req, 6);
    #3 rst_n = 1'b0;
    #1;
    check("t5_busy_rst", a_busy, 0);
    check("t5_valid_rst", a_valid, 0);
    check("t5_done_rst", a_done, 0);
    check("t5_readreq_rst", a_req, 0);
    exp_idx.delete();
    exp_dat.delete();
    #2 rst_n = 1'b1;
    a_ready = 1'b1;
    tick();
    check("t5_no_done_after_rst", a_done, 0);
    p0 = a_pops; d0 = a_dones;
    expect_sweep(30, 4);
    start_a(30, 4);
    tick();
    check("t5_first_index", a_idx, 30);
    check("t5_first_data", a_data, 32'h11E);
    wait_done_a(cyc);
    tick();
    check("t5_beats", a_pops - p0, 4);
    check("t5_done_count", a_dones - d0, 1);

    // Wrap at size=20
    b_base = 5'd18; b_count = 6'd4; b_start = 1'b1;
    tick();
    b_start = 1'b0;
    cyc = 0;
    while (!b_done && cyc < 50) begin
      tick();
      cyc++;
    end
    if (!b_done) check("b_done_timeout", b_done, 1);
    tick();
    check("b_beats", b_got_idx.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < b_got_idx.size()) begin
        check("b_index", b_got_idx[i], b_exp_tab[i]);
        check("b_data", b_got_dat[i], 32'h200 + b_exp_tab[i]);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
